auth_session_ctrl: RTL and testbench

AUTH_SESSION_CTRL -- requirements
Module: auth_session_ctrl

---
 rtl/auth_session_ctrl.sv | 145 ++++++++++++++
 tb/tb_auth_session_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/auth_session_ctrl.sv
// Authentication session controller: user-ID lookup, password check,
// timed denial and lockout, with one shared hold counter for all timed states.
module auth_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DENY_CYCLES    = 50,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       userid_pulse,
  input  logic       pswd_pulse,
  input  logic       logout_pulse,
  input  logic       userid_valid,
  input  logic [3:0] userid_index,
  input  logic       pswd_match,
  output logic       rom_rd,
  output logic [3:0] internalid,
  output logic       authorise_bit,
  output logic       greenled,
  output logic       redled,
  output logic       locked,
  output logic [1:0] fail_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ID_LOOKUP = 3'd1,
    WAIT_PSWD = 3'd2,
    PSWD_RD   = 3'd3,
    PSWD_CMP  = 3'd4,
    GRANTED   = 3'd5,
    DENIED    = 3'd6,
    LOCKED    = 3'd7
  } state_t;

  // Terminal counter values: the counter reads 0 on the first cycle in a state.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] DENY_LAST    = 16'(DENY_CYCLES - 1);
  localparam logic [15:0] LOCKOUT_LAST = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]  MAX_FAILS_2B = 2'(MAX_FAILS);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic [3:0]  id_reg, id_next;
  logic [1:0]  fails_reg, fails_next;
  logic [1:0]  fails_inc;

  // Failure count after one more denial, saturating at the lockout threshold.
  assign fails_inc = (fails_reg == MAX_FAILS_2B) ? fails_reg : fails_reg + 2'd1;

  // Next-state, latched-ID and failure-count logic.
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    fails_next = fails_reg;
    case (state_reg)
      IDLE: begin
        if (userid_pulse) state_next = ID_LOOKUP;
      end
      ID_LOOKUP: begin
        if (userid_valid) begin
          id_next    = userid_index;
          state_next = WAIT_PSWD;
        end else begin
          fails_next = fails_inc;
          state_next = DENIED;
        end
      end
      WAIT_PSWD: begin
        // Logout beats a restart, a restart beats a password attempt,
        // and any pulse beats the timeout.
        if (logout_pulse)              state_next = IDLE;
        else if (userid_pulse)         state_next = ID_LOOKUP;
        else if (pswd_pulse)           state_next = PSWD_RD;
        else if (cnt_reg == TIMEOUT_LAST) begin
          fails_next = fails_inc;
          state_next = DENIED;
        end
      end
      PSWD_RD: begin
        state_next = PSWD_CMP;
      end
      PSWD_CMP: begin
        if (pswd_match) begin
          fails_next = 2'd0;
          state_next = GRANTED;
        end else begin
          fails_next = fails_inc;
          state_next = DENIED;
        end
      end
      GRANTED: begin
        if (logout_pulse) state_next = IDLE;
      end
      DENIED: begin
        if (cnt_reg == DENY_LAST)
          state_next = (fails_reg == MAX_FAILS_2B) ? LOCKED : IDLE;
      end
      LOCKED: begin
        if (cnt_reg == LOCKOUT_LAST) begin
          fails_next = 2'd0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, latched ID and failure count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      id_reg    <= 4'd0;
      fails_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      fails_reg <= fails_next;
    end
  end

  // Shared hold counter: zero on any state change, counts only in timed states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= 16'd0;
    end else if (state_next != state_reg) begin
      cnt_reg <= 16'd0;
    end else if (state_reg == WAIT_PSWD || state_reg == DENIED || state_reg == LOCKED) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Outputs decoded purely from registered state.
  assign rom_rd        = (state_reg == PSWD_RD);
  assign authorise_bit = (state_reg == GRANTED);
  assign greenled      = (state_reg == GRANTED);
  assign redled        = (state_reg == DENIED) || (state_reg == LOCKED);
  assign locked        = (state_reg == LOCKED);
  assign internalid    = id_reg;
  assign fail_count    = fails_reg;
  assign state         = state_reg;

endmodule

// File: tb/tb_auth_session_ctrl.sv
// Directed bench for auth_session_ctrl: a vector table for the main flows,
// then hand-written sequences for lockout, reset mid-session and mid-lockout.
module tb_auth_session_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       userid_pulse = 1'b0, pswd_pulse = 1'b0, logout_pulse = 1'b0;
  logic       userid_valid = 1'b0;
  logic [3:0] userid_index = 4'd0;
  logic       pswd_match = 1'b0;
  logic       rom_rd, authorise_bit, greenled, redled, locked;
  logic [3:0] internalid;
  logic [1:0] fail_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Expected flag sets {rom_rd, authorise_bit, greenled, redled, locked}.
  localparam logic [4:0] F0   = 5'b00000;
  localparam logic [4:0] F_RD = 5'b10000;
  localparam logic [4:0] F_GR = 5'b01100;
  localparam logic [4:0] F_DN = 5'b00010;
  localparam logic [4:0] F_LK = 5'b00011;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOOK = 3'd1, S_WAIT = 3'd2, S_RD = 3'd3,
                         S_CMP = 3'd4, S_GR = 3'd5, S_DN = 3'd6, S_LK = 3'd7;

  auth_session_ctrl #(
    .TIMEOUT_CYCLES(8),
    .DENY_CYCLES(4),
    .LOCKOUT_CYCLES(16),
    .MAX_FAILS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .userid_pulse(userid_pulse),
    .pswd_pulse(pswd_pulse),
    .logout_pulse(logout_pulse),
    .userid_valid(userid_valid),
    .userid_index(userid_index),
    .pswd_match(pswd_match),
    .rom_rd(rom_rd),
    .internalid(internalid),
    .authorise_bit(authorise_bit),
    .greenled(greenled),
    .redled(redled),
    .locked(locked),
    .fail_count(fail_count),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, uid, pw, lo, uvalid;
    logic [3:0] uidx;
    logic       match;
    int         n;
    logic [2:0] st;
    logic [3:0] id;
    logic [1:0] fc;
    logic [4:0] fl;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, u, p, l, v, input logic [3:0] ix,
                              input logic m, input int n, input logic [2:0] st,
                              input logic [3:0] id, input logic [1:0] fc,
                              input logic [4:0] fl);
    vec_t t;
    t.rst_n = r; t.uid = u; t.pw = p; t.lo = l; t.uvalid = v; t.uidx = ix;
    t.match = m; t.n = n; t.st = st; t.id = id; t.fc = fc; t.fl = fl;
    return t;
  endfunction

  // Hold the given inputs for n clock cycles, then sample 1 time unit after the last edge.
  task automatic apply(input logic r, u, p, l, v, input logic [3:0] ix,
                       input logic m, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset = r; userid_pulse = u; pswd_pulse = p; logout_pulse = l;
      userid_valid = v; userid_index = ix; pswd_match = m;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [3:0] id,
                       input logic [1:0] fc, input logic [4:0] fl);
    logic [13:0] got, exp;
    got = {state, internalid, fail_count, rom_rd, authorise_bit, greenled, redled, locked};
    exp = {st, id, fc, fl};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d id=%h fc=%0d flags=%b, expected state=%0d id=%h fc=%0d flags=%b",
               name, state, internalid, fail_count,
               {rom_rd, authorise_bit, greenled, redled, locked}, st, id, fc, fl);
    end else begin
      $display("check %s: state=%0d id=%h fc=%0d flags=%b", name, state, internalid,
               fail_count, {rom_rd, authorise_bit, greenled, redled, locked});
    end
  endtask

  initial begin
    //                r  u  p  l  v  idx    m  n   state   id     fc  flags
    vecs[0]  = mk(0, 0, 0, 0, 0, 4'h0, 0, 2,  S_IDLE, 4'h0, 0, F0);   // reset
    vecs[1]  = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_IDLE, 4'h0, 0, F0);
    vecs[2]  = mk(1, 0, 1, 1, 0, 4'h0, 0, 1,  S_IDLE, 4'h0, 0, F0);   // pswd/logout ignored
    vecs[3]  = mk(1, 1, 0, 0, 0, 4'h0, 0, 1,  S_LOOK, 4'h0, 0, F0);   // good login
    vecs[4]  = mk(1, 0, 0, 0, 1, 4'h5, 0, 1,  S_WAIT, 4'h5, 0, F0);
    vecs[5]  = mk(1, 0, 1, 0, 0, 4'h0, 0, 1,  S_RD,   4'h5, 0, F_RD);
    vecs[6]  = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_CMP,  4'h5, 0, F0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 4'h0, 1, 1,  S_GR,   4'h5, 0, F_GR);
    vecs[8]  = mk(1, 1, 1, 0, 0, 4'h0, 0, 1,  S_GR,   4'h5, 0, F_GR); // pulses ignored
    vecs[9]  = mk(1, 0, 0, 1, 0, 4'h0, 0, 1,  S_IDLE, 4'h5, 0, F0);   // logout keeps id
    vecs[10] = mk(1, 1, 0, 0, 0, 4'h0, 0, 1,  S_LOOK, 4'h5, 0, F0);   // timeout
    vecs[11] = mk(1, 0, 0, 0, 1, 4'h9, 0, 1,  S_WAIT, 4'h9, 0, F0);
    vecs[12] = mk(1, 0, 0, 0, 0, 4'h0, 0, 7,  S_WAIT, 4'h9, 0, F0);
    vecs[13] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_DN,   4'h9, 1, F_DN);
    vecs[14] = mk(1, 1, 1, 1, 0, 4'h0, 0, 3,  S_DN,   4'h9, 1, F_DN); // pulses ignored
    vecs[15] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_IDLE, 4'h9, 1, F0);
    vecs[16] = mk(1, 1, 0, 0, 0, 4'h0, 0, 1,  S_LOOK, 4'h9, 1, F0);   // unknown ID
    vecs[17] = mk(1, 0, 0, 0, 0, 4'h3, 0, 1,  S_DN,   4'h9, 2, F_DN);
    vecs[18] = mk(1, 0, 0, 0, 0, 4'h0, 0, 4,  S_IDLE, 4'h9, 2, F0);
    vecs[19] = mk(1, 1, 0, 0, 0, 4'h0, 0, 1,  S_LOOK, 4'h9, 2, F0);   // logout+userid
    vecs[20] = mk(1, 0, 0, 0, 1, 4'hA, 0, 1,  S_WAIT, 4'hA, 2, F0);
    vecs[21] = mk(1, 1, 0, 1, 0, 4'h0, 0, 1,  S_IDLE, 4'hA, 2, F0);
    vecs[22] = mk(1, 1, 0, 0, 0, 4'h0, 0, 1,  S_LOOK, 4'hA, 2, F0);   // userid+pswd
    vecs[23] = mk(1, 0, 0, 0, 1, 4'hB, 0, 1,  S_WAIT, 4'hB, 2, F0);
    vecs[24] = mk(1, 1, 1, 0, 0, 4'h0, 0, 1,  S_LOOK, 4'hB, 2, F0);
    vecs[25] = mk(1, 0, 0, 0, 1, 4'hC, 0, 1,  S_WAIT, 4'hC, 2, F0);
    vecs[26] = mk(1, 0, 1, 0, 0, 4'h0, 0, 1,  S_RD,   4'hC, 2, F_RD); // wrong password
    vecs[27] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_CMP,  4'hC, 2, F0);
    vecs[28] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_DN,   4'hC, 3, F_DN);
    vecs[29] = mk(1, 0, 0, 0, 0, 4'h0, 0, 4,  S_LK,   4'hC, 3, F_LK);
    vecs[30] = mk(1, 1, 1, 1, 0, 4'h0, 0, 15, S_LK,   4'hC, 3, F_LK);
    vecs[31] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1,  S_IDLE, 4'hC, 0, F0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rst_n, vecs[i].uid, vecs[i].pw, vecs[i].lo, vecs[i].uvalid,
            vecs[i].uidx, vecs[i].match, vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].id, vecs[i].fc, vecs[i].fl);
    end

    // Three wrong-password attempts in a row lead to a full-length lockout.
    for (int k = 1; k <= 3; k++) begin
      apply(1, 1, 0, 0, 0, 4'h0, 0, 1);
      apply(1, 0, 0, 0, 1, 4'(k), 0, 1);
      apply(1, 0, 1, 0, 0, 4'h0, 0, 1);
      apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
      apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
      check($sformatf("wrongpw%0d_denied", k), S_DN, 4'(k), 2'(k), F_DN);
      apply(1, 0, 0, 0, 0, 4'h0, 0, 3);
      check($sformatf("wrongpw%0d_hold", k), S_DN, 4'(k), 2'(k), F_DN);
      apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
      if (k < 3) check($sformatf("wrongpw%0d_idle", k), S_IDLE, 4'(k), 2'(k), F0);
      else       check("wrongpw3_locked", S_LK, 4'h3, 2'd3, F_LK);
    end
    apply(1, 1, 1, 0, 0, 4'h0, 0, 15);
    check("lock_hold", S_LK, 4'h3, 2'd3, F_LK);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
    check("lock_release", S_IDLE, 4'h3, 2'd0, F0);

    // Reset while GRANTED clears everything; reset dominates a concurrent pulse.
    apply(1, 1, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 1, 4'h6, 0, 1);
    apply(1, 0, 1, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 1, 1);
    check("granted_before_reset", S_GR, 4'h6, 2'd0, F_GR);
    apply(0, 0, 0, 0, 0, 4'h0, 0, 1);
    check("reset_in_granted", S_IDLE, 4'h0, 2'd0, F0);
    apply(0, 1, 0, 0, 0, 4'h0, 0, 1);
    check("reset_blocks_pulse", S_IDLE, 4'h0, 2'd0, F0);
    apply(1, 1, 0, 0, 0, 4'h0, 0, 1);
    check("first_after_reset", S_LOOK, 4'h0, 2'd0, F0);

    // Three unknown IDs reach lockout quickly; then reset mid-lockout.
    apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 4);
    apply(1, 1, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 4);
    apply(1, 1, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
    check("badid3_denied", S_DN, 4'h0, 2'd3, F_DN);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 4);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 5);
    check("badid_locked", S_LK, 4'h0, 2'd3, F_LK);
    apply(0, 0, 0, 0, 0, 4'h0, 0, 1);
    check("reset_in_locked", S_IDLE, 4'h0, 2'd0, F0);

    // After reset the timeout runs its full length from a cleared counter.
    apply(1, 1, 0, 0, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 0, 1, 4'h7, 0, 1);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 7);
    check("timeout_edge_wait", S_WAIT, 4'h7, 2'd0, F0);
    apply(1, 0, 0, 0, 0, 4'h0, 0, 1);
    check("timeout_edge_denied", S_DN, 4'h7, 2'd1, F_DN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
